corelet_ppu: RTL and testbench

CORELET_PPU -- requirements
Module: corelet_ppu

---
 rtl/corelet_ppu.sv | 185 ++++++++++++++++++
 tb/tb_corelet_ppu.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/corelet_ppu.sv
// Post-processing unit: per-lane psum accumulation bank with ReLU drain.
// Define PPU_SAT_EN for saturating lane adds; otherwise adds wrap.
module corelet_ppu #(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned depth   = 16,
    localparam int unsigned AW     = (depth > 1) ? $clog2(depth) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   mode,
    input  logic                   relu_en,
    input  logic [AW:0]            cfg_len,
    input  logic [7:0]             cfg_taps,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [psum_bw*col-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [psum_bw*col-1:0] out_data,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {StIdle, StAcc, StDrain} state_e;

    localparam logic [AW:0] LenMax = (AW + 1)'(depth);
    localparam logic [AW:0] LenOne = (AW + 1)'(1);

`ifdef PPU_SAT_EN
    localparam logic [psum_bw-1:0] SatMax = {1'b0, {(psum_bw - 1){1'b1}}};
    localparam logic [psum_bw-1:0] SatMin = {1'b1, {(psum_bw - 1){1'b0}}};
`endif

    state_e              state_q, state_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [7:0]          tap_q, tap_d;
    logic [AW:0]         len_q, len_d;
    logic [7:0]          taps_q, taps_d;
    logic                relu_q, relu_d;
    logic                done_q, done_d;

    logic [psum_bw-1:0]  bank_q [depth][col];
    logic [psum_bw-1:0]  din_lane [col];
    logic [psum_bw:0]    sum_ext [col];
    logic [psum_bw-1:0]  wr_lane [col];
    logic [psum_bw-1:0]  rd_lane [col];

    logic xfer, out_beat, last_pos, last_tap, last_rd;

    assign in_ready  = (state_q == StAcc);
    assign out_valid = (state_q == StDrain);
    assign busy      = (state_q != StIdle);
    assign done      = done_q;

    assign xfer     = in_valid & in_ready;
    assign out_beat = out_valid & out_ready;
    assign last_pos = ({1'b0, wr_ptr_q} == (len_q - LenOne));
    assign last_tap = (tap_q == (taps_q - 8'd1));
    assign last_rd  = ({1'b0, rd_ptr_q} == (len_q - LenOne));

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        tap_d    = tap_q;
        len_d    = len_q;
        taps_d   = taps_q;
        relu_d   = relu_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d    = (cfg_len == '0 || cfg_len > LenMax) ? LenMax : cfg_len;
                    taps_d   = (cfg_taps == 8'd0 || mode) ? 8'd1 : cfg_taps;
                    relu_d   = relu_en;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    tap_d    = 8'd0;
                    state_d  = StAcc;
                end
            end
            StAcc: begin
                if (xfer) begin
                    if (last_pos) begin
                        wr_ptr_d = '0;
                        if (last_tap) begin
                            tap_d   = 8'd0;
                            state_d = StDrain;
                        end else begin
                            tap_d = tap_q + 8'd1;
                        end
                    end else begin
                        wr_ptr_d = wr_ptr_q + AW'(1);
                    end
                end
            end
            StDrain: begin
                if (out_beat) begin
                    if (last_rd) begin
                        rd_ptr_d = '0;
                        done_d   = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        rd_ptr_d = rd_ptr_q + AW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            tap_q    <= 8'd0;
            len_q    <= '0;
            taps_q   <= 8'd0;
            relu_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            tap_q    <= tap_d;
            len_q    <= len_d;
            taps_q   <= taps_d;
            relu_q   <= relu_d;
            done_q   <= done_d;
        end
    end

    // Sign-extended add leaves the overflow visible in the top two bits.
    always_comb begin
        for (int i = 0; i < col; i++) begin
            din_lane[i] = in_data[psum_bw*i +: psum_bw];
            sum_ext[i]  = {bank_q[wr_ptr_q][i][psum_bw-1], bank_q[wr_ptr_q][i]} +
                          {din_lane[i][psum_bw-1], din_lane[i]};
`ifdef PPU_SAT_EN
            if (sum_ext[i][psum_bw] != sum_ext[i][psum_bw-1]) begin
                wr_lane[i] = sum_ext[i][psum_bw] ? SatMin : SatMax;
            end else begin
                wr_lane[i] = sum_ext[i][psum_bw-1:0];
            end
`else
            wr_lane[i] = sum_ext[i][psum_bw-1:0];
`endif
            if (tap_q == 8'd0) begin
                wr_lane[i] = din_lane[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < depth; d++) begin
                for (int i = 0; i < col; i++) begin
                    bank_q[d][i] <= '0;
                end
            end
        end else if (xfer) begin
            for (int i = 0; i < col; i++) begin
                bank_q[wr_ptr_q][i] <= wr_lane[i];
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < col; i++) begin
            rd_lane[i] = bank_q[rd_ptr_q][i];
            if (relu_q && rd_lane[i][psum_bw-1]) begin
                rd_lane[i] = '0;
            end
            if (state_q == StDrain) begin
                out_data[psum_bw*i +: psum_bw] = rd_lane[i];
            end
        end
    end

endmodule

// File: tb/tb_corelet_ppu.sv
// Directed self-checking bench for corelet_ppu (default parameters).
`timescale 1ns/1ps
module tb_corelet_ppu;

    localparam int W = 128;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic         relu_en = 1'b0;
    logic [4:0]   cfg_len = '0;
    logic [7:0]   cfg_taps = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;

    corelet_ppu dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .relu_en   (relu_en),
        .cfg_len   (cfg_len),
        .cfg_taps  (cfg_taps),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Lane i = base + i*step.
    function automatic logic [W-1:0] lanes(input int base, input int step);
        logic [W-1:0] r;
        for (int i = 0; i < 8; i++) r[16*i +: 16] = 16'(base + i * step);
        return r;
    endfunction

    function automatic logic [W-1:0] alt(input logic [15:0] ev, input logic [15:0] od);
        logic [W-1:0] r;
        for (int i = 0; i < 8; i++) r[16*i +: 16] = (i % 2 == 0) ? ev : od;
        return r;
    endfunction

    task automatic do_start(input logic m, input logic r, input logic [4:0] l,
                            input logic [7:0] t);
        start = 1'b1; mode = m; relu_en = r; cfg_len = l; cfg_taps = t;
        @(posedge clk); #1;
        start = 1'b0; mode = 1'b0; relu_en = 1'b0; cfg_len = '0; cfg_taps = '0;
    endtask

    task automatic send_beat(input logic [W-1:0] d, input string tag);
        bit ok = 0;
        in_valid = 1'b1; in_data = d;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; @(posedge clk); #1; break; end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL %s send: in_ready never high (got 0, need 1)", tag); end
    endtask

    task automatic recv_check(input logic [W-1:0] exp, input string tag);
        bit ok = 0;
        logic [W-1:0] d = '0;
        out_ready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1; d = out_data; @(posedge clk); #1; break; end
        end
        out_ready = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_err++; $display("FAIL %s recv: out_valid never high (got 0, need 1)", tag);
        end else if (d !== exp) begin
            n_err++; $display("FAIL %s data: got %h need %h", tag, d, exp);
        end
    endtask

    task automatic test_reset;
        #2;
        n_cmp++;
        if ({in_ready, out_valid, busy, done} !== 4'b0000) begin
            n_err++; $display("FAIL reset_ctrl: got %b need 0000", {in_ready, out_valid, busy, done});
        end
        n_cmp++;
        if (out_data !== '0) begin n_err++; $display("FAIL reset_data: got %h need 0", out_data); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b need 0", busy); end
    endtask

    task automatic test_ws;
        do_start(1'b0, 1'b0, 5'd4, 8'd3);
        n_cmp++;
        if ({busy, in_ready} !== 2'b11) begin
            n_err++; $display("FAIL ws_acc: got %b need 11", {busy, in_ready});
        end
        for (int k = 0; k < 12; k++) send_beat(lanes(5, 0), "ws");
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b01) begin
            n_err++; $display("FAIL ws_drain_state: got %b need 01", {in_ready, out_valid});
        end
        done_cnt = 0;
        for (int b = 0; b < 4; b++) recv_check(lanes(15, 0), "ws");
        n_cmp++;
        if (done !== 1'b1) begin n_err++; $display("FAIL ws_done: got %b need 1", done); end
        repeat (3) @(posedge clk); #1;
        n_cmp++;
        if (done_cnt !== 1 || busy !== 1'b0) begin
            n_err++; $display("FAIL ws_done_pulse: got cnt %0d busy %b need 1 0", done_cnt, busy);
        end
    endtask

    task automatic test_os;
        do_start(1'b1, 1'b0, 5'd2, 8'd7);
        send_beat(lanes(100, 0), "os");
        send_beat(lanes(-3, 0), "os");
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_err++; $display("FAIL os_taps_forced: got rdy %b vld %b need 0 1", in_ready, out_valid);
        end
        recv_check(lanes(100, 0), "os_norelu");
        recv_check(lanes(-3, 0), "os_norelu");
        n_cmp++;
        if (done !== 1'b1) begin n_err++; $display("FAIL os_done: got %b need 1", done); end
        // Start lands in the done cycle; state is already IDLE so it is taken.
        do_start(1'b1, 1'b1, 5'd2, 8'd7);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL os_start_on_done: got %b need 1", in_ready); end
        send_beat(lanes(100, 0), "os_relu");
        send_beat(lanes(-3, 0), "os_relu");
        recv_check(lanes(100, 0), "os_relu");
        recv_check(lanes(0, 0), "os_relu");
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_saturation;
        logic [W-1:0] exp;
`ifdef PPU_SAT_EN
        exp = alt(16'h7FFF, 16'h8000);
`else
        exp = alt(16'hE000, 16'h2000);
`endif
        do_start(1'b0, 1'b0, 5'd1, 8'd2);
        send_beat(alt(16'h7000, 16'h9000), "sat");
        send_beat(alt(16'h7000, 16'h9000), "sat");
        recv_check(exp, "sat");
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        do_start(1'b0, 1'b0, 5'd4, 8'd1);
        for (int p = 0; p < 4; p++) send_beat(lanes(10 + 10 * p, 1), "bp");
        recv_check(lanes(10, 1), "bp");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== lanes(20, 1)) begin
                n_err++; $display("FAIL bp_hold: got vld %b %h need 1 %h", out_valid, out_data, lanes(20, 1));
            end
        end
        @(posedge clk); #1;
        for (int p = 1; p < 4; p++) recv_check(lanes(10 + 10 * p, 1), "bp");
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_len0_gaps;
        do_start(1'b0, 1'b0, 5'd0, 8'd0);
        for (int p = 0; p < 16; p++) begin
            send_beat(lanes(p * 8, 1), "len0");
            if (p == 5) begin
                start = 1'b1; mode = 1'b1; cfg_len = 5'd2;
                @(posedge clk); #1;
                start = 1'b0; mode = 1'b0; cfg_len = '0;
            end
            repeat (p % 3) begin @(posedge clk); #1; end
            if (p == 14) begin
                n_cmp++;
                if (in_ready !== 1'b1) begin n_err++; $display("FAIL len0_still_acc: got %b need 1", in_ready); end
            end
        end
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_err++; $display("FAIL len0_drain: got rdy %b vld %b need 0 1", in_ready, out_valid);
        end
        for (int p = 0; p < 16; p++) recv_check(lanes(p * 8, 1), "len0");
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        done_cnt = 0;
        do_start(1'b0, 1'b0, 5'd4, 8'd2);
        for (int p = 0; p < 3; p++) send_beat(lanes(7, 0), "rmid");
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({busy, in_ready, out_valid, done} !== 4'b0000 || out_data !== '0) begin
            n_err++; $display("FAIL rmid_reset: got %b %h need 0000 0", {busy, in_ready, out_valid, done}, out_data);
        end
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) @(posedge clk); #1;
        n_cmp++;
        if (done_cnt !== 0 || busy !== 1'b0) begin
            n_err++; $display("FAIL rmid_abort: got cnt %0d busy %b need 0 0", done_cnt, busy);
        end
        do_start(1'b0, 1'b0, 5'd4, 8'd2);
        for (int p = 0; p < 4; p++) send_beat(lanes(p, 2), "rmid_t0");
        for (int p = 0; p < 4; p++) send_beat(lanes(4, 1), "rmid_t1");
        for (int p = 0; p < 4; p++) recv_check(lanes(p + 4, 3), "rmid_next");
        repeat (3) @(posedge clk); #1;
        n_cmp++;
        if (done_cnt !== 1) begin n_err++; $display("FAIL rmid_done: got %0d need 1", done_cnt); end
    endtask

    initial begin
        test_reset;
        test_ws;
        test_os;
        test_saturation;
        test_backpressure;
        test_len0_gaps;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
